// File: rtl/message_checker.sv
// message_checker: scans decrypted RAM for an all-legal message, stepping the key on each failure.
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   start           decryptor done level; only a rising edge starts a scan
//   address_d, q_d  decrypted-RAM read address and data (data valid 2 clocks after the address)
//   key             current candidate key
//   restart         one-cycle pulse asking upstream to re-run with the new key
//   done/valid/exhausted  sticky search outcome flags
//   bad_index       index of the first illegal byte of the most recent failed attempt
module message_checker #(
  parameter int          MSG_LEN = 32,
  parameter logic [23:0] KEY_MAX = 24'h3FFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [7:0]  address_d,
  input  logic [7:0]  q_d,
  output logic [23:0] key,
  output logic        restart,
  output logic        done,
  output logic        valid,
  output logic        exhausted,
  output logic [7:0]  bad_index
);
  typedef enum logic [2:0] {IDLE, ADDR, WAIT, CHECK, FAIL, PASS, EXHAUST} state_t;
  localparam logic [7:0] LAST = 8'(MSG_LEN - 1);
  state_t      state_q, state_d;
  logic [7:0]  idx_q, idx_d, bad_q, bad_d;
  logic [23:0] key_q, key_d;
  logic        start_q;
  logic        trigger, legal;
  assign trigger = start & ~start_q;
  assign legal   = (q_d == 8'h20) || (q_d >= 8'h61 && q_d <= 8'h7A);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      key_q   <= '0;
      bad_q   <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      key_q   <= key_d;
      bad_q   <= bad_d;
      start_q <= start;
    end
  // ADDR and WAIT only cover the two-clock RAM latency; q_d is sampled in CHECK.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    key_d   = key_q;
    bad_d   = bad_q;
    restart = 1'b0;
    case (state_q)
      IDLE:  if (trigger) begin
               idx_d   = '0;
               state_d = ADDR;
             end
      ADDR:  state_d = WAIT;
      WAIT:  state_d = CHECK;
      CHECK: if (!legal) begin
               bad_d   = idx_q;
               state_d = FAIL;
             end else if (idx_q == LAST) begin
               state_d = PASS;
             end else begin
               idx_d   = idx_q + 8'd1;
               state_d = ADDR;
             end
      FAIL:  if (key_q < KEY_MAX) begin
               key_d   = key_q + 24'd1;
               restart = 1'b1;
               state_d = IDLE;
             end else begin
               state_d = EXHAUST;
             end
      default: ;
    endcase
  end
  assign address_d = idx_q;
  assign key       = key_q;
  assign bad_index = bad_q;
  assign done      = (state_q == PASS) || (state_q == EXHAUST);
  assign valid     = state_q == PASS;
  assign exhausted = state_q == EXHAUST;
endmodule

// File: tb/tb_message_checker.sv
// tb_message_checker: directed self-checking bench for message_checker with a 2-clock-latency RAM model.
module tb_message_checker;
  logic        clk = 1'b0;
  logic        rst_n, start, start2;
  logic [7:0]  address_d, q_d, bad_index, address_d2, bad_index2, r1;
  logic [7:0]  q_d2 = 8'h00;
  logic [23:0] key, key2;
  logic        restart, done, valid, exhausted;
  logic        restart2, done2, valid2, exhausted2;
  logic [7:0]  ram [32];
  logic [7:0]  bads [4] = '{8'h1F, 8'h60, 8'h7B, 8'hFF};
  string       fox = "the quick brown fox jumps over ";
  int          n_chk = 0, n_pass = 0;
  int          at, rs, n;

  always #5 clk = ~clk;

  message_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .address_d(address_d), .q_d(q_d),
    .key(key), .restart(restart), .done(done), .valid(valid), .exhausted(exhausted),
    .bad_index(bad_index)
  );

  message_checker #(.MSG_LEN(32), .KEY_MAX(24'd2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .address_d(address_d2), .q_d(q_d2),
    .key(key2), .restart(restart2), .done(done2), .valid(valid2), .exhausted(exhausted2),
    .bad_index(bad_index2)
  );

  always @(posedge clk) begin
    r1  <= ram[address_d[4:0]];
    q_d <= r1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic rst_outs(input string p);
    chk({p, "_addr"}, address_d, 0);
    chk({p, "_key"}, key, 0);
    chk({p, "_restart"}, restart, 0);
    chk({p, "_done"}, done, 0);
    chk({p, "_valid"}, valid, 0);
    chk({p, "_exh"}, exhausted, 0);
    chk({p, "_bad"}, bad_index, 0);
  endtask

  task automatic load_fox();
    for (int i = 0; i < 32; i++) ram[i] = (i < fox.len()) ? fox[i] : 8'h20;
  endtask

  // Negedges counted from the call until the first restart or done; 0 means the bound expired.
  task automatic scan(input bit two, input int max, output int a, output int r);
    logic rr, dd;
    a = 0;
    r = 0;
    for (int c = 1; c <= max; c++) begin
      @(negedge clk);
      rr = two ? restart2 : restart;
      dd = two ? done2 : done;
      if (rr || dd) begin
        a = c;
        r = int'(rr);
        break;
      end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    start2 = 1'b0;
    load_fox();
    repeat (2) @(negedge clk);
    rst_outs("rst");

    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b1;
    scan(0, 200, at, rs);
    chk("pass_at", at, 97);
    chk("pass_restart", rs, 0);
    chk("pass_done", done, 1);
    chk("pass_valid", valid, 1);
    chk("pass_exh", exhausted, 0);
    chk("pass_key", key, 0);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (restart) n++;
    end
    chk("term_done", done, 1);
    chk("term_valid", valid, 1);
    chk("term_restart", n, 0);

    rst_n = 1'b0;
    #1 rst_outs("arst");
    ram[5] = 8'h41;
    @(negedge clk);
    rst_n = 1'b1;
    scan(0, 200, at, rs);
    chk("bad5_at", at, 19);
    chk("bad5_restart", rs, 1);
    chk("bad5_idx", bad_index, 5);
    chk("bad5_key_fail", key, 0);
    @(negedge clk);
    chk("bad5_pulse_end", restart, 0);
    chk("bad5_key", key, 1);
    chk("bad5_done", done, 0);
    n = 0;
    repeat (100) begin
      @(negedge clk);
      if (restart) n++;
    end
    chk("hold_restart", n, 0);
    chk("hold_key", key, 1);

    ram[5] = 8'h61;
    ram[0] = 8'h20;
    ram[1] = 8'h61;
    ram[2] = 8'h7A;
    for (int i = 0; i < 4; i++) begin
      ram[31] = bads[i];
      start = 1'b0;
      @(negedge clk);
      start = 1'b1;
      scan(0, 200, at, rs);
      chk($sformatf("b%0h_at", bads[i]), at, 97);
      chk($sformatf("b%0h_restart", bads[i]), rs, 1);
      chk($sformatf("b%0h_idx", bads[i]), bad_index, 31);
      @(negedge clk);
      chk($sformatf("b%0h_key", bads[i]), key, 32'(i + 2));
    end
    ram[31] = 8'h7A;
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    scan(0, 200, at, rs);
    chk("edge_at", at, 97);
    chk("edge_restart", rs, 0);
    chk("edge_valid", valid, 1);
    chk("edge_key", key, 5);

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    load_fox();
    ram[3] = 8'h7B;
    @(negedge clk);
    start = 1'b1;
    scan(0, 200, at, rs);
    chk("pre_at", at, 13);
    chk("pre_restart", rs, 1);
    @(negedge clk);
    start = 1'b0;
    ram[3] = 8'h61;
    chk("pre_key", key, 1);
    @(negedge clk);
    start = 1'b1;
    n = 0;
    repeat (33) begin
      @(negedge clk);
      if (restart) n++;
    end
    chk("mid_addr_before", address_d, 10);
    chk("mid_key_before", key, 1);
    chk("mid_no_restart", n, 0);
    rst_n = 1'b0;
    #1 rst_outs("mid");
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if (restart) n++;
    end
    chk("mid_after_restart", n, 0);
    start = 1'b1;
    scan(0, 200, at, rs);
    chk("mid_rescan_at", at, 97);
    chk("mid_rescan_restart", rs, 0);
    chk("mid_rescan_valid", valid, 1);
    chk("mid_rescan_key", key, 0);

    start2 = 1'b1;
    scan(1, 50, at, rs);
    chk("exh1_at", at, 4);
    chk("exh1_restart", rs, 1);
    @(negedge clk);
    chk("exh1_key", key2, 1);
    start2 = 1'b0;
    @(negedge clk);
    start2 = 1'b1;
    scan(1, 50, at, rs);
    chk("exh2_at", at, 4);
    chk("exh2_restart", rs, 1);
    @(negedge clk);
    chk("exh2_key", key2, 2);
    start2 = 1'b0;
    @(negedge clk);
    start2 = 1'b1;
    scan(1, 50, at, rs);
    chk("exh3_at", at, 5);
    chk("exh3_restart", rs, 0);
    chk("exh3_done", done2, 1);
    chk("exh3_exh", exhausted2, 1);
    chk("exh3_valid", valid2, 0);
    chk("exh3_key", key2, 2);
    chk("exh3_bad", bad_index2, 0);
    chk("exh3_addr", address_d2, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
